// File: rtl/man_charge_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : man_charge_meter_if
// Description : Bundle between the game FSM / physics engine (master side)
//               and the jump-charge meter (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface man_charge_meter_if #(
  parameter int OUT_W = 8
);
  logic [2:0]       state;
  logic             i_btn;
  logic             i_jump_done;
  logic [OUT_W-1:0] o_jump_v_init;
  logic             o_v_valid;
  logic [OUT_W-1:0] o_charge_level;
  logic             o_charge_full;

  // Game FSM / physics side: drives game state and button, consumes results
  modport master (
    output state, i_btn, i_jump_done,
    input  o_jump_v_init, o_v_valid, o_charge_level, o_charge_full
  );

  // Meter side
  modport slave (
    input  state, i_btn, i_jump_done,
    output o_jump_v_init, o_v_valid, o_charge_level, o_charge_full
  );
endinterface
`default_nettype wire

// File: rtl/man_charge_meter.sv
`default_nettype none
// ============================================================================
// Module      : man_charge_meter
// Description : Jump-charge meter. Charges a counter while the button is held
//               in the accumulate game state (saturating or ping-pong), then
//               latches a floored jump velocity on release with a one-cycle
//               valid strobe. Live level/full decode the counter for the HUD.
// Revision    : 1.0 - initial release
// ============================================================================
module man_charge_meter #(
  parameter int CNT_W     = 24,
  parameter int OUT_W     = 8,
  parameter int STEP      = 1,
  parameter int MODE      = 0,
  parameter int MIN_V     = 1,
  parameter int ACCU_CODE = 3,
  parameter int JUMP_CODE = 4
) (
  input  wire                clk_machine,
  input  wire                rst_machine_n,
  man_charge_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_LOCKED = 2'd2
  } fsm_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_STEP    = CNT_W'(STEP);
  // Any count at or above this would overshoot the top on the next step
  localparam logic [CNT_W-1:0] C_TOP_THR = C_CNT_MAX - C_STEP;
  localparam logic [OUT_W-1:0] C_MIN_V   = OUT_W'(MIN_V);
  localparam logic [2:0]       C_ACCU    = 3'(ACCU_CODE);
  localparam logic [2:0]       C_JUMP    = 3'(JUMP_CODE);

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;       // 0 = counting up, 1 = counting down
  logic [OUT_W-1:0] v_init_q, v_init_d;
  logic             v_valid_q, v_valid_d;

  logic             w_accu;
  logic             w_jump;
  logic             w_abort;
  logic [OUT_W-1:0] w_level;

  assign w_accu  = (bus.state == C_ACCU);
  assign w_jump  = (bus.state == C_JUMP);
  assign w_abort = !w_accu && !w_jump;
  assign w_level = cnt_q[CNT_W-1 -: OUT_W];

  // Next-state, counter step and release/abort handling
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    v_init_d  = v_init_q;
    v_valid_d = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        cnt_d    = '0;
        dir_d    = 1'b0;
        v_init_d = '0;
        if (w_accu && bus.i_btn) begin
          cnt_d = C_STEP;
          fsm_d = ST_CHARGE;
        end
      end

      ST_CHARGE: begin
        if (w_abort) begin
          cnt_d    = '0;
          dir_d    = 1'b0;
          v_init_d = '0;
          fsm_d    = ST_IDLE;
        end else if ((w_accu && !bus.i_btn) || w_jump) begin
          // Release: latch the floored level, counter stays frozen
          v_init_d  = (w_level < C_MIN_V) ? C_MIN_V : w_level;
          v_valid_d = 1'b1;
          fsm_d     = ST_LOCKED;
        end else if (MODE == 0) begin
          cnt_d = (cnt_q >= C_TOP_THR) ? C_CNT_MAX : cnt_q + C_STEP;
        end else if (!dir_q) begin
          if (cnt_q >= C_TOP_THR) begin
            cnt_d = C_CNT_MAX;
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + C_STEP;
          end
        end else begin
          if (cnt_q <= C_STEP) begin
            cnt_d = '0;
            dir_d = 1'b0;
          end else begin
            cnt_d = cnt_q - C_STEP;
          end
        end
      end

      ST_LOCKED: begin
        // Button is ignored here so the player cannot re-charge mid-jump
        if (w_abort || (w_jump && bus.i_jump_done)) begin
          cnt_d    = '0;
          dir_d    = 1'b0;
          v_init_d = '0;
          fsm_d    = ST_IDLE;
        end
      end

      default: begin
        cnt_d    = '0;
        dir_d    = 1'b0;
        v_init_d = '0;
        fsm_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_machine or negedge rst_machine_n) begin
    if (!rst_machine_n) begin
      fsm_q     <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      v_init_q  <= '0;
      v_valid_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      v_init_q  <= v_init_d;
      v_valid_q <= v_valid_d;
    end
  end

  assign bus.o_jump_v_init  = v_init_q;
  assign bus.o_v_valid      = v_valid_q;
  assign bus.o_charge_level = w_level;
  assign bus.o_charge_full  = (cnt_q == C_CNT_MAX);

endmodule
`default_nettype wire
